spi_frame_tx: RTL and testbench
===============================

// Module: spi_frame_tx
// PURPOSE
//   Serialises one parallel word per request into an SPI-style frame (spi_en, spi_clk, spi_data).
//   It is the transmit counterpart of the design's SPI input path, whose receiver:
//     - synchronises spi_clk through 2 flops, then samples spi_data on its rising edge;
//     - shifts data in at the LSB, so frames go out MSB first;
//     - restarts its bit count on the rising edge of spi_en.
//   Used to stream pixel results to the host, and as a loopback driver for the coordinate receiver.
// PARAMETERS
//   FRAME_BITS  32  data bits per frame (>=2)
//   CLK_DIV     4   clk cycles per spi_clk half-period (>=3, so the receiver's synchroniser and edge detector see every edge)
//   GAP_CYCLES  4   minimum clk cycles spi_en stays low between frames (>=3)
// PORTS
//   clk       in   1           system clock
//   nrst      in   1           asynchronous active-low reset
//   tx_valid  in   1           request: tx_data is valid
//   tx_data   in   FRAME_BITS  word to send; captured on accept
//   tx_ready  out  1           block idle; a request is accepted when tx_valid & tx_ready
//   tx_done   out  1           one-cycle pulse when a frame (including gap) completes
//   spi_en    out  1           frame enable, high for the whole frame
//   spi_clk   out  1           serial clock, idle low; receiver samples on the rising edge
//   spi_data  out  1           serial data, MSB first; changes only while spi_clk is low
// BEHAVIOUR
//   - Interface: one clock; reset is asynchronous and active-low (clk, nrst).
//   - All spi_* outputs and tx_done are registered.
//   - Reset values: spi_en=0, spi_clk=0, spi_data=0, tx_done=0, tx_ready=1, shift register=0, counters=0.
//   - FSM states: IDLE -> LEAD -> SHIFT -> GAP -> IDLE.
//     - tx_ready = (state==IDLE). tx_valid is ignored outside IDLE; tx_data is not required to be held after accept.
//     - IDLE: spi_en=0, spi_clk=0, spi_data=0. On accept, load the shift register from tx_data and go to LEAD.
//     - LEAD (CLK_DIV cycles): spi_en=1, spi_clk=0, spi_data=tx_data[FRAME_BITS-1].
//     - SHIFT: NBITS bit periods, each CLK_DIV cycles with spi_clk high then CLK_DIV cycles low.
//       On each high->low transition, the next bit is presented on spi_data.
//       After the final low half, go to GAP.
//     - GAP (GAP_CYCLES cycles): spi_en=0, spi_clk=0, spi_data=0.
//       tx_done pulses on the cycle the FSM re-enters IDLE, coincident with tx_ready rising.
//   - Latency: spi_en rises 1 cycle after the accept edge.
//     - tx_done asserts CLK_DIV*(1+2*NBITS)+GAP_CYCLES cycles after accept.
//     - Next accept is possible on that same cycle.
//   - Half-period counter: width $clog2(CLK_DIV); counts 0..CLK_DIV-1, then wraps to 0.
//   - Bit counter: width $clog2(NBITS+1); saturates at NBITS and clears on accept.
//   - Back-to-back requests: tx_valid held high sends frames continuously.
//     - spi_en stays low for exactly GAP_CYCLES between frames, so the receiver always sees a fresh spi_en rising edge.
//   - Reset mid-frame: all outputs return to reset values immediately and the partial frame is abandoned.
//     - No tx_done is issued. The first request after reset starts a clean frame.
//   - No counter value outside its legal range is reachable; the default FSM branch returns to IDLE.
// CONFIGURATION
//   SPI_TX_PARITY_EN defined: one even-parity bit (^tx_data) is appended after the LSB, so NBITS = FRAME_BITS+1.
//   SPI_TX_PARITY_EN undefined: NBITS = FRAME_BITS and no parity logic is built.
// TESTING
//   1. Apply nrst=0 mid-simulation -> spi_en/spi_clk/spi_data/tx_done = 0 and tx_ready = 1, asynchronously.
//   2. FRAME_BITS=32, CLK_DIV=4, GAP=4; send 32'hA5A5_0F0F ->
//      - exactly 32 spi_clk rising edges;
//      - the bits sampled on those edges equal A5A50F0F, MSB first;
//      - spi_en is high for 260 cycles;
//      - tx_done pulses 264 cycles after accept;
//      - tx_ready stays low throughout.
//   3. Loopback into the SPI receiver (width 2, depth 16); send 32'h1234_8765 ->
//      - receiver data_out == 32'h1234_8765;
//      - its valid_data pulses exactly once.
//   4. Hold tx_valid=1 with three words queued ->
//      - three frames are sent, each accepted on the tx_done cycle;
//      - spi_en is low for exactly 4 cycles between frames;
//      - all three words are received intact.
//   5. Drop nrst during bit 10, release, then send 32'h0000_0001 ->
//      - no tx_done for the aborted frame;
//      - the receiver gets 32'h0000_0001.
//   6. With SPI_TX_PARITY_EN defined, send 32'h0000_0007 ->
//      - 33 rising edges, with the final sampled bit = 1;
//      - tx_done at 4*(1+66)+4 = 272 cycles after accept.

Source files
------------

// File: rtl/spi_frame_tx.sv
// SPI-style frame transmitter: one parallel word per request, sent MSB first on spi_data.
// Define SPI_TX_PARITY_EN to append an even-parity bit after the LSB.
module spi_frame_tx #(
    parameter int FRAME_BITS = 32,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  tx_valid,
    input  logic [FRAME_BITS-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  tx_done,
    output logic                  spi_en,
    output logic                  spi_clk,
    output logic                  spi_data
);

`ifdef SPI_TX_PARITY_EN
    localparam int NBITS = FRAME_BITS + 1;
`else
    localparam int NBITS = FRAME_BITS;
`endif
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(NBITS + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS);
    // IDLE supplies the last low gap cycle, so a held tx_valid re-raises spi_en exactly GAP_CYCLES later.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 2);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, GAP} state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [NBITS-1:0]   shift_q, shift_d;
    logic               spi_en_q, spi_en_d;
    logic               spi_clk_q, spi_clk_d;
    logic               spi_data_q, spi_data_d;
    logic               tx_done_q, tx_done_d;
    logic [NBITS-1:0]   load_word;

`ifdef SPI_TX_PARITY_EN
    assign load_word = {tx_data, ^tx_data};
`else
    assign load_word = tx_data;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            gap_q      <= '0;
            shift_q    <= '0;
            spi_en_q   <= 1'b0;
            spi_clk_q  <= 1'b0;
            spi_data_q <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            shift_q    <= shift_d;
            spi_en_q   <= spi_en_d;
            spi_clk_q  <= spi_clk_d;
            spi_data_q <= spi_data_d;
            tx_done_q  <= tx_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        gap_d      = gap_q;
        shift_d    = shift_q;
        spi_en_d   = spi_en_q;
        spi_clk_d  = spi_clk_q;
        spi_data_d = spi_data_q;
        tx_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                spi_en_d   = 1'b0;
                spi_clk_d  = 1'b0;
                spi_data_d = 1'b0;
                if (tx_valid) begin
                    state_d    = LEAD;
                    shift_d    = load_word;
                    div_d      = '0;
                    bit_d      = '0;
                    gap_d      = '0;
                    spi_en_d   = 1'b1;
                    spi_data_d = tx_data[FRAME_BITS-1];
                end
            end
            LEAD: begin
                if (div_q == DIV_LAST) begin
                    div_d     = '0;
                    spi_clk_d = 1'b1;
                    state_d   = SHIFT;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (spi_clk_q) begin
                        // Falling edge: present the next bit while the clock is low.
                        spi_clk_d  = 1'b0;
                        shift_d    = {shift_q[NBITS-2:0], 1'b0};
                        spi_data_d = shift_q[NBITS-2];
                        if (bit_q != BIT_LAST) begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else if (bit_q == BIT_LAST) begin
                        state_d    = GAP;
                        spi_en_d   = 1'b0;
                        spi_data_d = 1'b0;
                        gap_d      = '0;
                    end else begin
                        spi_clk_d = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d     = '0;
                    state_d   = IDLE;
                    tx_done_d = 1'b1;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                spi_en_d   = 1'b0;
                spi_clk_d  = 1'b0;
                spi_data_d = 1'b0;
            end
        endcase
    end

    assign tx_ready = (state_q == IDLE);
    assign tx_done  = tx_done_q;
    assign spi_en   = spi_en_q;
    assign spi_clk  = spi_clk_q;
    assign spi_data = spi_data_q;

endmodule

// File: tb/tb_spi_frame_tx.sv
// Bench for spi_frame_tx: frame-timing model checked every cycle, plus a behavioural SPI receiver.
module tb_spi_frame_tx;
    localparam int FB = 32;
    localparam int CD = 4;
    localparam int GC = 4;
`ifdef SPI_TX_PARITY_EN
    localparam int NB = FB + 1;
`else
    localparam int NB = FB;
`endif
    localparam int EN_LEN    = CD * (1 + 2 * NB);
    localparam int FRAME_LEN = EN_LEN + GC;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          tx_valid = 1'b0;
    logic [FB-1:0] tx_data = '0;
    logic          tx_ready, tx_done, spi_en, spi_clk, spi_data;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    spi_frame_tx #(.FRAME_BITS(FB), .CLK_DIV(CD), .GAP_CYCLES(GC)) dut (
        .clk(clk), .nrst(nrst), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .tx_done(tx_done),
        .spi_en(spi_en), .spi_clk(spi_clk), .spi_data(spi_data)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Bit i of the serial stream (0 = first bit on the wire).
    function automatic logic stream_bit(input int i, input logic [FB-1:0] w);
        if (i < FB) return w[FB-1-i];
`ifdef SPI_TX_PARITY_EN
        if (i == FB) return ^w;
`endif
        return 1'b0;
    endfunction

    // Expected {spi_en, spi_clk, spi_data, tx_done, tx_ready} r cycles after the accept cycle.
    function automatic logic [4:0] frame_out(input int r, input logic [FB-1:0] w);
        int q, b, ph;
        if (r >= 1 && r <= EN_LEN) begin
            if (r <= CD) return {1'b1, 1'b0, stream_bit(0, w), 2'b00};
            q  = r - CD - 1;
            b  = q / (2 * CD);
            ph = q % (2 * CD);
            if (ph < CD) return {1'b1, 1'b1, stream_bit(b, w), 2'b00};
            return {1'b1, 1'b0, stream_bit(b + 1, w), 2'b00};
        end
        if (r > EN_LEN && r < FRAME_LEN) return 5'b00000;
        return 5'b00011;
    endfunction

    // Per-cycle model compare.
    initial begin
        bit            active;
        int            start, r;
        logic [FB-1:0] word;
        logic [4:0]    exp_v;
        active = 0; start = 0; word = '0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                active = 0;
                chk("reset_outputs", {spi_en, spi_clk, spi_data, tx_done, tx_ready}, 5'b00001);
            end else begin
                r = active ? (cyc - start) : 0;
                exp_v = (active && r <= FRAME_LEN) ? frame_out(r, word) : 5'b00001;
                chk($sformatf("cycle_outputs r=%0d", r),
                    {spi_en, spi_clk, spi_data, tx_done, tx_ready}, exp_v);
                if (!active || r >= FRAME_LEN) begin
                    active = 0;
                    if (tx_valid) begin
                        active = 1;
                        start  = cyc;
                        word   = tx_data;
                    end
                end
            end
        end
    end

    // Behavioural receiver and timing recorder.
    logic [63:0] word_q[$];
    int          edge_q[$], len_q[$], gap_q[$], lat_q[$];
    logic        lastb_q[$], accd_q[$];
    int          done_cnt = 0;

    initial begin
        logic        prev_en, prev_clk, last_bit;
        logic [63:0] rx_sh;
        int          edges, en_len, low_run, acc_cyc;
        prev_en = 0; prev_clk = 0; last_bit = 0; rx_sh = '0;
        edges = 0; en_len = 0; low_run = 0; acc_cyc = 0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                prev_en = 0; prev_clk = 0; rx_sh = '0; edges = 0; en_len = 0; low_run = 0;
            end else begin
                if (tx_done) begin
                    done_cnt++;
                    lat_q.push_back(cyc - acc_cyc);
                end
                if (tx_valid && tx_ready) begin
                    acc_cyc = cyc;
                    accd_q.push_back(tx_done);
                end
                if (spi_en && !prev_en) begin
                    gap_q.push_back(low_run);
                    rx_sh = '0; edges = 0; en_len = 0;
                end
                if (!spi_en && prev_en) begin
                    word_q.push_back(rx_sh);
                    edge_q.push_back(edges);
                    len_q.push_back(en_len);
                    lastb_q.push_back(last_bit);
                    low_run = 0;
                end
                if (spi_en) begin
                    en_len++;
                    if (spi_clk && !prev_clk) begin
                        rx_sh    = {rx_sh[62:0], spi_data};
                        last_bit = spi_data;
                        edges++;
                    end
                end else begin
                    low_run++;
                end
                prev_en  = spi_en;
                prev_clk = spi_clk;
            end
        end
    end

    task automatic clear_q();
        word_q.delete(); edge_q.delete(); len_q.delete(); gap_q.delete();
        lat_q.delete(); lastb_q.delete(); accd_q.delete();
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!tx_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk({name, "_done_timeout"}, 64'd0, 64'd1);
        @(negedge clk);
    endtask

    task automatic send(input logic [FB-1:0] w);
        int n = 0;
        @(posedge clk); #1;
        tx_valid = 1'b1;
        tx_data  = w;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_ready && n < 2000);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_data  = $urandom;
    endtask

    task automatic chk_rx(input string name, input int idx, input logic [FB-1:0] w);
        logic [63:0] got;
        if (word_q.size() > idx) begin
            got = word_q[idx] >> (NB - FB);
            chk({name, "_word"}, got, {32'd0, w});
        end else begin
            chk({name, "_word_missing"}, 64'(word_q.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        int            d0;
        int            n;
        logic [FB-1:0] ws[3];
        ws[0] = 32'hDEAD_BEEF; ws[1] = 32'h0123_4567; ws[2] = 32'h8000_0001;
        repeat (3) @(negedge clk);
        chk("reset_initial", {spi_en, spi_clk, spi_data, tx_done, tx_ready}, 5'b00001);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

`ifndef SPI_TX_PARITY_EN
        // A5A5_0F0F: edges, bit order, spi_en width, done latency.
        clear_q();
        send(32'hA5A5_0F0F);
        wait_done("a5");
        chk_rx("a5", 0, 32'hA5A5_0F0F);
        chk("a5_edges", 64'(edge_q.size() > 0 ? edge_q[0] : -1), 64'd32);
        chk("a5_en_len", 64'(len_q.size() > 0 ? len_q[0] : -1), 64'd260);
        chk("a5_latency", 64'(lat_q.size() > 0 ? lat_q[0] : -1), 64'd264);
`endif

        // Loopback word.
        clear_q();
        send(32'h1234_8765);
        wait_done("loop");
        chk_rx("loop", 0, 32'h1234_8765);
        chk("loop_frames", 64'(word_q.size()), 64'd1);

        // Back-to-back with tx_valid held high.
        clear_q();
        @(posedge clk); #1;
        tx_valid = 1'b1;
        tx_data  = ws[0];
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!tx_ready && n < 2000);
            if (n >= 2000) chk("b2b_ready_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
            tx_data = (k < 2) ? ws[k+1] : 32'h0;
        end
        tx_valid = 1'b0;
        n = 0;
        while (word_q.size() < 3 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        wait_done("b2b");
        for (int k = 0; k < 3; k++) chk_rx($sformatf("b2b%0d", k), k, ws[k]);
        for (int k = 1; k < 3; k++) begin
            chk($sformatf("b2b_gap%0d", k), 64'(gap_q.size() > k ? gap_q[k] : -1), 64'd4);
            chk($sformatf("b2b_acc_on_done%0d", k), 64'(accd_q.size() > k ? accd_q[k] : 1'b0), 64'd1);
        end

        // Abort with reset during bit 10, then a clean frame.
        clear_q();
        d0 = done_cnt;
        @(posedge clk); #1;
        tx_valid = 1'b1;
        tx_data  = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (85) @(posedge clk);
        #2 nrst = 1'b0;
        #1 chk("abort_async_reset", {spi_en, spi_clk, spi_data, tx_done, tx_ready}, 5'b00001);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (300) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt), 64'(d0));
        send(32'h0000_0001);
        wait_done("after_abort");
        chk_rx("after_abort", 0, 32'h0000_0001);
        chk("after_abort_done", 64'(done_cnt), 64'(d0 + 1));

`ifdef SPI_TX_PARITY_EN
        clear_q();
        send(32'h0000_0007);
        wait_done("par");
        chk_rx("par", 0, 32'h0000_0007);
        chk("par_edges", 64'(edge_q.size() > 0 ? edge_q[0] : -1), 64'd33);
        chk("par_last_bit", 64'(lastb_q.size() > 0 ? lastb_q[0] : 1'b0), 64'd1);
        chk("par_latency", 64'(lat_q.size() > 0 ? lat_q[0] : -1), 64'd272);
`endif

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
